// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative HI/LO unit for the MIPS pipeline.
// Runs a one-bit-per-cycle shift-add multiplier (and a restoring divider
// when MULT_DIV_SEQ_DIV_EN is defined) and owns the architectural HI/LO registers.
// Without MULT_DIV_SEQ_DIV_EN the divider is not built, and DIV/DIVU starts are ignored.
// HI/LO change only when a result is committed or on an MTHI/MTLO write.

module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mtHi,
    input  logic             mtLo,
    input  logic [WIDTH-1:0] mtData,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stateT;

    stateT              state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               negProd;
`ifdef MULT_DIV_SEQ_DIV_EN
    logic               isDiv;
    logic               negQuot;
    logic               negRem;
`endif

    logic               signedOp;
    logic               startLegal;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] multFinal;
    logic [WIDTH:0]     multSum;
    logic [WIDTH-1:0]   resultHi;
    logic [WIDTH-1:0]   resultLo;
`ifdef MULT_DIV_SEQ_DIV_EN
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     remDiff;
    logic               remFits;
`endif

    assign signedOp = ~op[0];
    assign busy     = ~ready;

`ifdef MULT_DIV_SEQ_DIV_EN
    assign startLegal = start;
`else
    assign startLegal = start & ~op[1];
`endif

    // Operand magnitudes at launch: signed ops take |x|, unsigned ops pass straight through.
    always_comb begin
        absA = srcA;
        absB = srcB;
        if (signedOp && srcA[WIDTH-1]) begin
            absA = ~srcA + 1'b1;
        end
        if (signedOp && srcB[WIDTH-1]) begin
            absB = ~srcB + 1'b1;
        end
    end

    // One engine step: shift-add for multiply, restore-or-subtract for divide; then sign fixup of the final step.
    always_comb begin
        multSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        accNext = {multSum, acc[WIDTH-1:1]};
`ifdef MULT_DIV_SEQ_DIV_EN
        remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        remDiff  = remShift - {1'b0, operand};
        remFits  = ~remDiff[WIDTH];
        if (isDiv) begin
            accNext = {(remFits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0]),
                       acc[WIDTH-2:0], remFits};
        end
`endif
        multFinal = negProd ? (~accNext + 1'b1) : accNext;
        resultHi  = multFinal[2*WIDTH-1:WIDTH];
        resultLo  = multFinal[WIDTH-1:0];
`ifdef MULT_DIV_SEQ_DIV_EN
        if (isDiv) begin
            resultLo = negQuot ? (~accNext[WIDTH-1:0] + 1'b1) : accNext[WIDTH-1:0];
            resultHi = negRem ? (~accNext[2*WIDTH-1:WIDTH] + 1'b1) : accNext[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // Sequencer: MTHI/MTLO beat start, start beats (and abandons) an op in flight, otherwise iterate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            negProd <= 1'b0;
`ifdef MULT_DIV_SEQ_DIV_EN
            isDiv   <= 1'b0;
            negQuot <= 1'b0;
            negRem  <= 1'b0;
`endif
            hi      <= '0;
            lo      <= '0;
            ready   <= 1'b1;
        end else if (mtHi || mtLo) begin
            if (mtHi) begin
                hi <= mtData;
            end
            if (mtLo) begin
                lo <= mtData;
            end
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
        end else if (startLegal) begin
            state   <= BUSY;
            cnt     <= '0;
            ready   <= 1'b0;
            negProd <= signedOp & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
`ifdef MULT_DIV_SEQ_DIV_EN
            isDiv   <= op[1];
            negQuot <= signedOp & (srcA[WIDTH-1] ^ srcB[WIDTH-1]) & (srcB != '0);
            negRem  <= signedOp & srcA[WIDTH-1];
            if (op[1]) begin
                acc     <= {{WIDTH{1'b0}}, absA};
                operand <= absB;
            end else begin
                acc     <= {{WIDTH{1'b0}}, absB};
                operand <= absA;
            end
`else
            acc     <= {{WIDTH{1'b0}}, absB};
            operand <= absA;
`endif
        end else if (state == BUSY) begin
            acc <= accNext;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                hi    <= resultHi;
                lo    <= resultLo;
                state <= IDLE;
                cnt   <= '0;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed self-checking bench for mult_div_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
// Divider cases run when MULT_DIV_SEQ_DIV_EN is defined; otherwise DIV starts are checked as ignored.

module tb_mult_div_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        mtHi;
    logic        mtLo;
    logic [31:0] mtData;
    logic        ready;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int passCount;
    int checkCount;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .mtHi   (mtHi),
        .mtLo   (mtLo),
        .mtData (mtData),
        .ready  (ready),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Pulse start for one cycle; returns on the falling edge just after the launch edge.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = opIn;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges seen with ready low, bounded so a stuck DUT cannot hang the run.
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expected);
        int cycles;
        applyStimulus(opIn, a, b);
        waitReady(cycles);
        checkOutput({tag, " latency"}, 64'(cycles), 64'd32);
        checkOutput({tag, " hi:lo"}, {hi, lo}, expected);
    endtask

    // Directed scenarios in sequence; each expected value is worked out by hand.
    initial begin
        int  cycles;
        bit  sawTwelve;

        passCount  = 0;
        checkCount = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = OP_MULT;
        srcA   = '0;
        srcB   = '0;
        mtHi   = 1'b0;
        mtLo   = 1'b0;
        mtData = '0;

        #12;
        checkOutput("reset hi:lo", {hi, lo}, 64'h0);
        checkOutput("reset ready/busy", {62'd0, ready, busy}, 64'b10);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (16) @(negedge clk);
        checkOutput("multu hold old hi:lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("multu busy mid-op", {62'd0, ready, busy}, 64'b01);
        waitReady(cycles);
        checkOutput("multu latency", 64'(cycles + 16), 64'd32);
        checkOutput("multu max hi:lo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        runOp("mult -7*-6", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A);
        runOp("mult minneg^2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Restart while busy: the 3x4 product must never reach HI/LO.
        sawTwelve = 1'b0;
        applyStimulus(OP_MULTU, 32'd3, 32'd4);
        repeat (8) begin
            if (lo == 32'd12) sawTwelve = 1'b1;
            @(negedge clk);
        end
        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        cycles = 0;
        while (!ready && cycles < 100) begin
            if (lo == 32'd12) sawTwelve = 1'b1;
            cycles++;
            @(negedge clk);
        end
        checkOutput("restart latency", 64'(cycles), 64'd32);
        checkOutput("restart hi:lo", {hi, lo}, 64'd42);
        checkOutput("restart no stale 12", 64'(sawTwelve), 64'd0);

        // MTLO during a multiply aborts it and leaves HI alone.
        applyStimulus(OP_MULT, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        mtLo   = 1'b1;
        mtData = 32'd1234;
        @(negedge clk);
        mtLo = 1'b0;
        checkOutput("mtlo abort hi:lo", {hi, lo}, {32'd0, 32'd1234});
        checkOutput("mtlo abort ready", 64'(ready), 64'd1);
        repeat (40) @(negedge clk);
        checkOutput("mtlo abort stays", {hi, lo}, {32'd0, 32'd1234});

        // MTHI+MTLO together with start: both written, start dropped.
        @(negedge clk);
        mtHi   = 1'b1;
        mtLo   = 1'b1;
        mtData = 32'hCAFE_F00D;
        start  = 1'b1;
        op     = OP_MULTU;
        srcA   = 32'd2;
        srcB   = 32'd2;
        @(negedge clk);
        mtHi  = 1'b0;
        mtLo  = 1'b0;
        start = 1'b0;
        checkOutput("mt beats start ready", 64'(ready), 64'd1);
        repeat (40) @(negedge clk);
        checkOutput("mt both hi:lo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

`ifdef MULT_DIV_SEQ_DIV_EN
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("divu 7/0", OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        runOp("div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
        runOp("div minneg/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
`else
        // Divider not built: DIV/DIVU starts must leave everything untouched.
        applyStimulus(OP_DIV, 32'd7, 32'd2);
        checkOutput("div ignored ready", 64'(ready), 64'd1);
        applyStimulus(OP_DIVU, 32'd9, 32'd3);
        checkOutput("divu ignored ready", 64'(ready), 64'd1);
        repeat (40) @(negedge clk);
        checkOutput("div ignored hi:lo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
`endif

        // Asynchronous reset mid-multiply clears everything before the next edge.
        applyStimulus(OP_MULT, 32'd5, 32'd5);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset hi:lo", {hi, lo}, 64'h0);
        checkOutput("async reset ready/busy", {62'd0, ready, busy}, 64'b10);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("post reset idle", {31'd0, ready, hi}, {31'd0, 1'b1, 32'd0});
        checkOutput("post reset lo", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
